// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types for the pipelined adder
// Purpose: operation encoding and the per-stage control payload that travels
//          alongside the WIDTH-bit partial sum and pending operands.
// Ports:   none (package).
package pipe_adder_pkg;

   typedef enum logic [1:0] {
      ADD       = 2'b00,
      SUB       = 2'b01,
      ADD_SAT_U = 2'b10,
      ADD_SAT_S = 2'b11
   } mode_e;

   // Width-independent part of a stage payload; the WIDTH-sized partial sum
   // and pending A/effB vectors travel next to it on separate ports so the
   // package stays free of design parameters.
   typedef struct packed {
      logic  valid;
      mode_e mode;
      logic  carry;
   } stage_ctrl_t;

   function automatic logic is_sub(input mode_e m);
      return (m == SUB);
   endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// rtl/adder_chunk_stage.sv - one CHUNK-bit carry-propagating pipeline stage
// Purpose: adds chunk IDX of A and effective B plus the incoming carry,
//          merges the result into the partial sum and registers everything
//          when en is high.
// Ports:   clk, rst (sync, active-high), en (pipeline advance),
//          ctrl_i/sum_i/a_i/b_i payload from the previous stage,
//          ctrl_o/sum_o/a_o/b_o registered payload to the next stage.
module adder_chunk_stage
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int IDX   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  stage_ctrl_t       ctrl_i,
   input  logic [WIDTH-1:0]  sum_i,
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  b_i,
   output stage_ctrl_t       ctrl_o,
   output logic [WIDTH-1:0]  sum_o,
   output logic [WIDTH-1:0]  a_o,
   output logic [WIDTH-1:0]  b_o
);

   logic [CHUNK:0]     chunk_add;
   stage_ctrl_t        ctrl_d, ctrl_q;
   logic [WIDTH-1:0]   sum_d, sum_q, a_q, b_q;

   assign chunk_add = {1'b0, a_i[IDX*CHUNK +: CHUNK]}
                    + {1'b0, b_i[IDX*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, ctrl_i.carry};

   always_comb begin
      sum_d                      = sum_i;
      sum_d[IDX*CHUNK +: CHUNK]  = chunk_add[CHUNK-1:0];
      ctrl_d                     = ctrl_i;
      ctrl_d.carry               = chunk_add[CHUNK];
   end

   // The valid bit always shifts on advance so bubbles are preserved; the
   // data registers only load for real beats, which keeps the last result
   // on the outputs while bubbles pass through.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         sum_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
      end else if (en) begin
         ctrl_q.valid <= ctrl_i.valid;
         if (ctrl_i.valid) begin
            ctrl_q.mode  <= ctrl_d.mode;
            ctrl_q.carry <= ctrl_d.carry;
            sum_q        <= sum_d;
            a_q          <= a_i;
            b_q          <= b_i;
         end
      end
   end

   assign ctrl_o = ctrl_q;
   assign sum_o  = sum_q;
   assign a_o    = a_q;
   assign b_o    = b_q;

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/sub/saturating adder with valid/ready
// Purpose: WIDTH-bit add split into WIDTH/CHUNK registered chunk stages,
//          latency STAGES, one beat per cycle, full backpressure.
// Ports:   clk, rst (sync, active-high),
//          in_valid/in_ready/a/b/mode  operand beat,
//          out_valid/out_ready/sum/carry/ovf  result beat.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   // WIDTH must be a multiple of CHUNK.
   localparam int STAGES = WIDTH / CHUNK;
   localparam int MSB    = WIDTH - 1;

   logic             advance;
   mode_e            mode_in;
   logic [WIDTH-1:0] b_eff;

   stage_ctrl_t      ctrl_s [0:STAGES];
   logic [WIDTH-1:0] sum_s  [0:STAGES];
   logic [WIDTH-1:0] a_s    [0:STAGES];
   logic [WIDTH-1:0] b_s    [0:STAGES];

   // The whole pipe moves as one; it only stops when a valid result is
   // being held against a busy consumer.
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance && !rst;

   // Subtraction is A + ~B + 1: invert B here, inject the 1 as carry-in.
   assign mode_in = mode_e'(mode);
   assign b_eff   = is_sub(mode_in) ? ~b : b;

   assign ctrl_s[0] = '{valid: (in_valid && in_ready),
                        mode:  mode_in,
                        carry: is_sub(mode_in)};
   assign sum_s[0]  = '0;
   assign a_s[0]    = a;
   assign b_s[0]    = b_eff;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_chunk_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .en     (advance),
         .ctrl_i (ctrl_s[k]),
         .sum_i  (sum_s[k]),
         .a_i    (a_s[k]),
         .b_i    (b_s[k]),
         .ctrl_o (ctrl_s[k+1]),
         .sum_o  (sum_s[k+1]),
         .a_o    (a_s[k+1]),
         .b_o    (b_s[k+1])
      );
   end

   logic             cout;
   logic             ovf_raw;
   logic [WIDTH-1:0] raw;
   logic             a_msb, b_msb;
   mode_e            mode_l;

   assign out_valid = ctrl_s[STAGES].valid;
   assign raw       = sum_s[STAGES];
   assign cout      = ctrl_s[STAGES].carry;
   assign mode_l    = ctrl_s[STAGES].mode;
   assign a_msb     = a_s[STAGES][MSB];
   assign b_msb     = b_s[STAGES][MSB];

   // Signed overflow: operands agree in sign but the result does not.
   assign ovf_raw = (a_msb == b_msb) && (raw[MSB] != a_msb);

   // Flags and saturation are combinational from the last stage registers,
   // so they hold exactly as long as that stage holds.
   always_comb begin
      sum   = raw;
      carry = cout;
      ovf   = ovf_raw;
      case (mode_l)
         SUB:       carry = !cout;
         ADD_SAT_U: if (cout) sum = '1;
         ADD_SAT_S: if (ovf_raw) sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
         default:   ;
      endcase
   end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder
module tb_pipe_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, sum;
   logic [1:0]  mode;
   logic        carry, ovf;

   int checks = 0;
   int passes = 0;

   pipe_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Reference: plain arithmetic on the operation definitions.
   // Returns {carry, ovf, sum}.
   function automatic logic [33:0] model(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
      logic [32:0] u;
      longint      s;
      logic [31:0] r;
      logic        c, v;
      if (m == 2'b01) begin
         r = x - y;
         c = (x < y);
         s = longint'($signed(x)) - longint'($signed(y));
      end else begin
         u = {1'b0, x} + {1'b0, y};
         r = u[31:0];
         c = u[32];
         s = longint'($signed(x)) + longint'($signed(y));
      end
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      if (m == 2'b10 && c) r = 32'hFFFF_FFFF;
      if (m == 2'b11 && v) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return {c, v, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input string tag, input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] es, input logic ec, input logic ev);
      int lat;
      out_ready = 1'b1;
      mode = m; a = x; b = y; in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_sum"},   64'(sum),   64'(es));
      check({tag, "_carry"}, 64'(carry), 64'(ec));
      check({tag, "_ovf"},   64'(ovf),   64'(ev));
      tick();
   endtask

   logic [33:0] exp_q[$];

   initial begin
      int i, got, sent, stall, cyc;
      logic tog, hold;

      // Reset state
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = 2'b00;
      tick();
      check("rst_in_ready_low", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      check("post_rst_sum", 64'(sum), 64'd0);
      check("post_rst_flags", 64'({carry, ovf}), 64'd0);

      // Directed corner operations
      send_one("t1_add_xchunk", 2'b00, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
      send_one("t2_add_wrap",   2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
      send_one("t2_sub_borrow", 2'b01, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0);
      send_one("t3_sats_pos",   2'b11, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
      send_one("t3_sats_neg",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      send_one("t3_satu",       2'b10, 32'hFFFF_FFF0, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 1'b0);

      // Back-to-back beats with a 3-cycle stall on the first result
      exp_q.delete();
      i = 0; got = 0; stall = -1; cyc = 0;
      while (got < 8 && cyc < 100) begin
         in_valid = (i < 8); mode = 2'b00; a = 32'(i); b = 32'(100 * i);
         if (stall < 0 && out_valid) stall = 3;
         out_ready = !(stall > 0);
         #1;
         if (stall > 0) begin
            check("t4_stall_in_ready", 64'(in_ready), 64'd0);
            check("t4_stall_out_valid", 64'(out_valid), 64'd1);
            check("t4_stall_held", 64'({carry, ovf, sum}), 64'(exp_q[0]));
         end else begin
            check("t4_flow_in_ready", 64'(in_ready), 64'd1);
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(mode, a, b));
            i++;
         end
         if (out_valid && out_ready) begin
            check("t4_result", 64'({carry, ovf, sum}), 64'(exp_q.pop_front()));
            got++;
         end
         tick();
         if (stall > 0) stall--;
         cyc++;
      end
      in_valid = 1'b0;
      check("t4_count", 64'(got), 64'd8);
      check("t4_result_101x7", 64'(model(2'b00, 32'd7, 32'd700)), 64'd707);

      // Reset with beats in flight
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; mode = 2'b00; a = 32'(k + 1); b = 32'(k + 1);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t5_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("t5_out_valid_after_rst", 64'(out_valid), 64'd0);
      check("t5_in_ready_after_rst", 64'(in_ready), 64'd1);
      got = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_valid) got++;
      end
      check("t5_no_flushed_beats", 64'(got), 64'd0);
      send_one("t5_after_rst", 2'b00, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

      // Randomised traffic against the reference model
      exp_q.delete();
      sent = 0; got = 0; cyc = 0; tog = 1'b0; hold = 1'b0; in_valid = 1'b0;
      while (got < 1000 && cyc < 20000) begin
         tog = !tog;
         if (!hold) begin
            in_valid = tog && (sent < 1000);
            mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
               0:       a = 32'h7FFF_FFFF;
               1:       a = 32'h8000_0000;
               2:       a = 32'hFFFF_FFFF;
               default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         hold = in_valid && !in_ready;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(mode, a, b));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("t6_unexpected_beat", 64'd1, 64'd0);
            else check("t6_result", 64'({carry, ovf, sum}), 64'(exp_q.pop_front()));
            got++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check("t6_sent", 64'(sent), 64'd1000);
      check("t6_received", 64'(got), 64'd1000);
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
